axi_txn_limiter: RTL
====================

Name: axi_txn_limiter

Overview:
- Sits directly downstream of the AXI multi-cut register chain, before the downstream slave port.
- Limits the number of outstanding write transactions (AW accepted, B not yet returned) and read transactions (AR accepted, last R not yet returned).
- Each address channel has a one-entry registered stage. Address valid is therefore never withdrawn downstream, even when the credit limit is reached.
- W, B and R payloads bypass the block. It only observes B and R-last completion pulses.

Parameters:
- MaxWrTxns, 8, max outstanding writes; legal range 1..255.
- MaxRdTxns, 8, max outstanding reads; legal range 1..255.
- AwWidth, 64, packed AW channel payload width in bits.
- ArWidth, 64, packed AR channel payload width in bits.
- CntWidth, 8, status counter width; must be at least $clog2(max(MaxWrTxns,MaxRdTxns)+1).

Ports:
- clk_i  in  1  clock, rising edge
- rst_i  in  1  synchronous reset, active-high
- slv_aw_i  in  AwWidth  upstream AW payload
- slv_aw_valid_i  in  1  upstream AW valid
- slv_aw_ready_o  out  1  upstream AW ready
- mst_aw_o  out  AwWidth  downstream AW payload (registered)
- mst_aw_valid_o  out  1  downstream AW valid
- mst_aw_ready_i  in  1  downstream AW ready
- slv_ar_i  in  ArWidth  upstream AR payload
- slv_ar_valid_i  in  1  upstream AR valid
- slv_ar_ready_o  out  1  upstream AR ready
- mst_ar_o  out  ArWidth  downstream AR payload (registered)
- mst_ar_valid_o  out  1  downstream AR valid
- mst_ar_ready_i  in  1  downstream AR ready
- b_done_i  in  1  B handshake pulse (b_valid & b_ready)
- r_last_done_i  in  1  R handshake pulse with r_last set
- wr_cnt_o  out  CntWidth  outstanding write count
- rd_cnt_o  out  CntWidth  outstanding read count
- err_o  out  1  sticky: completion pulse seen while the matching count was 0

Behaviour:
- Reset:
  - Clock and reset: one clock (clk_i); reset rst_i is synchronous and active-high.
  - All valids, counts and err_o are 0; payload registers are 0.
  - slv_*_ready_o is 0 while rst_i is high.
  - A reset mid-transaction drops the buffered address and clears the counts. Completions still in flight are the integrator's responsibility.
- Per channel (AW shown; AR is identical with MaxRdTxns and r_last_done_i):
  - Credit: credit_ok = (wr_cnt < MaxWrTxns).
  - Slave ready: slv_aw_ready_o = credit_ok & (!mst_aw_valid_o | mst_aw_ready_i). This is combinational and independent of slv_aw_valid_i.
  - Accept: on slv_aw_valid_i & slv_aw_ready_o, the payload is registered and mst_aw_valid_o is set the next cycle. Latency is 1 cycle.
  - Back-to-back accept and drain in the same cycle sustains 1 transaction per cycle.
  - Drain: on mst_aw_valid_o & mst_aw_ready_i with no new accept, mst_aw_valid_o clears next cycle.
  - Stability: the payload is stable while mst_aw_valid_o is high and ready is low.
- Counter:
  - Increments on an upstream accept and decrements on b_done_i.
  - Both in the same cycle: unchanged.
  - Count reaching MaxWrTxns: slv_aw_ready_o drops the same cycle. A completion pulse reopens ready combinationally on the next cycle, after the count update.
  - Completion while the count is 0: the count stays 0 and err_o sets and holds until reset.
- Channels are fully independent. Simultaneous events on AW and AR never interact.
- W data is not gated. Bursts whose AW is buffered may proceed; the downstream ordering rules still hold because AW always leaves in order.

Decomposition:
- Shared package axi_txn_limiter_pkg: default constants (MaxTxnsDefault = 8) and a function cnt_width(max) returning $clog2(max+1).
- Sub-module axi_txn_limiter_chan #(Width, MaxTxns, CntWidth):
  - Contains one registered address stage, the credit counter and the error flag.
  - Instantiated twice (AW, AR); err_o is the OR of the two channel flags.

Test Plan:
- Reset, then AW valid with 0xA5 payload and mst ready=1 -> mst_aw_valid_o high 1 cycle later with payload 0xA5, wr_cnt_o=1.
- MaxWrTxns=2, three back-to-back AW with no b_done_i -> third stalls with slv_aw_ready_o=0 and wr_cnt_o=2. Pulse b_done_i -> third accepted next cycle, wr_cnt_o returns to 2.
- Downstream ready held 0 for 5 cycles -> mst_aw_o and mst_aw_valid_o stable all 5 cycles, slv_aw_ready_o=0; ready=1 then drains.
- Accept and b_done_i in the same cycle at count 3 -> count remains 3. Continuous streaming with ready=1 and completions every cycle -> 1 txn/cycle.
- r_last_done_i pulse with rd_cnt_o=0 -> rd_cnt_o stays 0, err_o=1 and held until rst_i.
- rst_i asserted with 2 reads outstanding and AR buffered -> next cycle mst_ar_valid_o=0, rd_cnt_o=0, slv_ar_ready_o=0 during reset.

Source files
------------

// File: rtl/axi_txn_limiter_pkg.sv
// axi_txn_limiter_pkg
//   Shared constants and helpers for the AXI outstanding-transaction limiter.
//   - MaxTxnsDefault : default outstanding-transaction limit per direction
//   - cnt_width()    : minimum counter width able to hold 0..max
package axi_txn_limiter_pkg;

  localparam int unsigned MaxTxnsDefault = 8;

  function automatic int unsigned cnt_width(input int unsigned max);
    return $clog2(max + 1);
  endfunction

endpackage

// File: rtl/axi_txn_limiter_chan.sv
// axi_txn_limiter_chan
//   One address channel: a single registered address stage gated by a credit
//   counter of outstanding transactions, plus a sticky underflow flag.
//   Ports:
//     clk_i, rst_i             clock, synchronous active-high reset
//     slv_i/slv_valid_i/slv_ready_o   upstream address handshake
//     mst_o/mst_valid_o/mst_ready_i   downstream address handshake (registered)
//     done_i                   completion pulse (B or last R handshake)
//     cnt_o                    outstanding transaction count
//     err_o                    sticky: completion seen while count was 0
module axi_txn_limiter_chan
  import axi_txn_limiter_pkg::*;
#(
  parameter int unsigned Width    = 64,
  parameter int unsigned MaxTxns  = MaxTxnsDefault,
  parameter int unsigned CntWidth = 8
) (
  input  logic                clk_i,
  input  logic                rst_i,
  input  logic [Width-1:0]    slv_i,
  input  logic                slv_valid_i,
  output logic                slv_ready_o,
  output logic [Width-1:0]    mst_o,
  output logic                mst_valid_o,
  input  logic                mst_ready_i,
  input  logic                done_i,
  output logic [CntWidth-1:0] cnt_o,
  output logic                err_o
);

  localparam logic [CntWidth-1:0] MaxCnt = CntWidth'(MaxTxns);

  logic [Width-1:0]    data_q, data_d;
  logic                valid_q, valid_d;
  logic [CntWidth-1:0] cnt_q, cnt_d;
  logic                err_q, err_d;
  logic                credit_ok, accept, dec;

  always_comb begin
    credit_ok   = (cnt_q < MaxCnt);
    // Stage can take a new beat when empty or when it is draining this cycle.
    slv_ready_o = !rst_i && credit_ok && (!valid_q || mst_ready_i);
    accept      = slv_valid_i && slv_ready_o;
    // A completion at count 0 is an underflow: ignored for counting, flagged.
    dec         = done_i && (cnt_q != '0);

    data_d  = accept ? slv_i : data_q;
    valid_d = accept ? 1'b1 : (valid_q && !mst_ready_i);

    cnt_d = cnt_q;
    if (accept && !dec)      cnt_d = cnt_q + CntWidth'(1);
    else if (!accept && dec) cnt_d = cnt_q - CntWidth'(1);

    err_d = err_q || (done_i && (cnt_q == '0));
  end

  always_ff @(posedge clk_i) begin
    if (rst_i) begin
      data_q  <= '0;
      valid_q <= 1'b0;
      cnt_q   <= '0;
      err_q   <= 1'b0;
    end else begin
      data_q  <= data_d;
      valid_q <= valid_d;
      cnt_q   <= cnt_d;
      err_q   <= err_d;
    end
  end

  assign mst_o       = data_q;
  assign mst_valid_o = valid_q;
  assign cnt_o       = cnt_q;
  assign err_o       = err_q;

endmodule

// File: rtl/axi_txn_limiter.sv
// axi_txn_limiter
//   Caps outstanding AXI write (AW..B) and read (AR..last R) transactions.
//   Each address channel passes through a one-entry register stage, so a
//   downstream valid is never withdrawn when the credit limit is hit; the
//   limit only holds off upstream ready. W/B/R payloads bypass this block.
//   Ports:
//     clk_i, rst_i                       clock, synchronous active-high reset
//     slv_aw_*, mst_aw_*                 AW channel in / registered out
//     slv_ar_*, mst_ar_*                 AR channel in / registered out
//     b_done_i, r_last_done_i            completion pulses
//     wr_cnt_o, rd_cnt_o                 outstanding counts
//     err_o                              sticky completion-underflow flag
module axi_txn_limiter
  import axi_txn_limiter_pkg::*;
#(
  parameter int unsigned MaxWrTxns = MaxTxnsDefault,
  parameter int unsigned MaxRdTxns = MaxTxnsDefault,
  parameter int unsigned AwWidth   = 64,
  parameter int unsigned ArWidth   = 64,
  parameter int unsigned CntWidth  = 8
) (
  input  logic                clk_i,
  input  logic                rst_i,
  input  logic [AwWidth-1:0]  slv_aw_i,
  input  logic                slv_aw_valid_i,
  output logic                slv_aw_ready_o,
  output logic [AwWidth-1:0]  mst_aw_o,
  output logic                mst_aw_valid_o,
  input  logic                mst_aw_ready_i,
  input  logic [ArWidth-1:0]  slv_ar_i,
  input  logic                slv_ar_valid_i,
  output logic                slv_ar_ready_o,
  output logic [ArWidth-1:0]  mst_ar_o,
  output logic                mst_ar_valid_o,
  input  logic                mst_ar_ready_i,
  input  logic                b_done_i,
  input  logic                r_last_done_i,
  output logic [CntWidth-1:0] wr_cnt_o,
  output logic [CntWidth-1:0] rd_cnt_o,
  output logic                err_o
);

  logic wr_err, rd_err;

  axi_txn_limiter_chan #(
    .Width(AwWidth), .MaxTxns(MaxWrTxns), .CntWidth(CntWidth)
  ) u_aw (
    .clk_i       (clk_i),
    .rst_i       (rst_i),
    .slv_i       (slv_aw_i),
    .slv_valid_i (slv_aw_valid_i),
    .slv_ready_o (slv_aw_ready_o),
    .mst_o       (mst_aw_o),
    .mst_valid_o (mst_aw_valid_o),
    .mst_ready_i (mst_aw_ready_i),
    .done_i      (b_done_i),
    .cnt_o       (wr_cnt_o),
    .err_o       (wr_err)
  );

  axi_txn_limiter_chan #(
    .Width(ArWidth), .MaxTxns(MaxRdTxns), .CntWidth(CntWidth)
  ) u_ar (
    .clk_i       (clk_i),
    .rst_i       (rst_i),
    .slv_i       (slv_ar_i),
    .slv_valid_i (slv_ar_valid_i),
    .slv_ready_o (slv_ar_ready_o),
    .mst_o       (mst_ar_o),
    .mst_valid_o (mst_ar_valid_o),
    .mst_ready_i (mst_ar_ready_i),
    .done_i      (r_last_done_i),
    .cnt_o       (rd_cnt_o),
    .err_o       (rd_err)
  );

  assign err_o = wr_err | rd_err;

endmodule
